camera_stream_tx: RTL and testbench
===================================

Name: camera_stream_tx

Overview:
Camera-side pixel stream transmitter. Reads a stored RGB565 frame from a synchronous frame memory and emits it byte-serially with OV7670-style VSYNC/HREF framing on CAMERA_CLK. It is the counterpart of the capture path that samples camera pixels and writes them to memory, so a stored image can be replayed into the capture/processing chain cycle-accurately. One frame is sent per start pulse.

Parameters:
IMG_W, 320, active pixels per line
IMG_H, 240, active lines per frame
ADDR_W, 17, frame memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
VSYNC_CYC, 4, cycles vsync is high at frame start
VBP_CYC, 10, vertical back porch cycles after vsync, before line 0; minimum 2
HBLK_CYC, 8, horizontal blanking cycles between lines; minimum 2
VFP_CYC, 10, vertical front porch cycles after the last line

Ports:
CAMERA_CLK  in   1       sole clock, rising edge
rst         in   1       asynchronous, active-low reset
start       in   1       one-cycle pulse; begins a frame when in IDLE
busy        out  1       high from the first VSYNC cycle through the DONE cycle
frame_done  out  1       one-cycle pulse after the front porch
rd_en       out  1       frame memory read strobe
rd_addr     out  ADDR_W  frame memory read address
rd_data     in   16      RGB565 pixel; valid the cycle after rd_en (1-cycle sync RAM)
vsync       out  1       frame sync
href        out  1       line valid
cam_data    out  8       pixel byte; high byte first, then low byte

Behaviour:
- Reset: asynchronous on rst=0. All outputs 0; state IDLE; x, y and address counters 0. Asserting reset mid-frame aborts the frame immediately. No frame_done is issued, and the module waits in IDLE for a new start.
- States: IDLE -> VSYNC -> VBP -> LINE -> (HBLK -> LINE)* -> VFP -> DONE -> IDLE.
- IDLE: start=1 at an edge moves to VSYNC. In every other state start is ignored.
- VSYNC: lasts VSYNC_CYC cycles. vsync=1, href=0.
- VBP: lasts VBP_CYC cycles. vsync=0, href=0.
- LINE: lasts 2*IMG_W cycles. href=1.
  - Pixel x occupies two cycles: cam_data = pix[15:8], then pix[7:0].
- HBLK: lasts HBLK_CYC cycles. href=0. HBLK follows every line except the last.
- After line IMG_H-1, go to VFP (VFP_CYC cycles), then DONE.
- DONE: 1 cycle; frame_done=1 and busy=1. Next cycle is IDLE with busy=0.
- cam_data is registered and is 0 whenever href=0.
- Memory reads:
  - Exactly one rd_en pulse per pixel, with rd_addr = y*IMG_W + x.
  - The address runs linearly from 0 to IMG_W*IMG_H-1 and does not wrap within a frame.
  - The read for a pixel is issued exactly 2 cycles before its high byte appears on cam_data:
    - for the first pixel of a line, in the second-to-last cycle of VBP/HBLK;
    - otherwise, in the high-byte cycle of the previous pixel.
  - rd_data is captured into the pixel register the cycle after rd_en.
- rd_en=0 and rd_addr holds its last value outside reads. rd_addr returns to 0 in IDLE.
- Counters: x wraps IMG_W-1 -> 0 with y+1. y reaching IMG_H-1 at the end of a line selects VFP.
- Blanking counters reload at each state entry.

Optional Feature:
TEST_PATTERN_EN
- Defined: an extra input port pattern_sel (1 bit) is added.
  - pattern_sel=1 sampled at start latches a pattern mode for the whole frame.
  - In pattern mode the pixel is {y[7:0], x[7:0]}, rd_en is never asserted, and framing is unchanged.
  - pattern_sel=0 gives normal memory mode.
- Undefined: the port is absent and the pixel always comes from rd_data.

Test Plan:
All scenarios use IMG_W=4, IMG_H=2, VSYNC_CYC=3, VBP_CYC=2, HBLK_CYC=2, VFP_CYC=2, with start sampled at edge 0 and the RAM model holding mem[a]=16'hA000+a.
- Full frame timing -> vsync=1 cycles 1-3; href=1 cycles 6-13 and 16-23; frame_done=1 only at cycle 26; busy=1 cycles 1-26.
- Data order -> cam_data over cycles 6-13 reads A0,00,A0,01,A0,02,A0,03; line 1 reads A0,04 ... A0,07. cam_data=0 in every href=0 cycle.
- Read timing -> rd_en pulses at cycles 4,6,8,10 (addresses 0-3) and 14,16,18,20 (addresses 4-7); exactly 8 pulses per frame.
- start pulsed at cycles 10 and 26, and again in IDLE at cycle 27 -> the first two are ignored; the third starts a new frame with vsync=1 at cycle 28.
- rst=0 at cycle 12 (mid line 0) -> all outputs 0 asynchronously; no frame_done. After release, a new start gives a full frame from address 0.
- TEST_PATTERN_EN with pattern_sel=1 -> line 1 bytes are 01,00,01,01,01,02,01,03; rd_en stays 0 for the whole frame.

Source files
------------

// File: rtl/camera_stream_tx.sv
// Replays a stored RGB565 frame as an OV7670-style byte stream (VSYNC/HREF framing).
// Define TEST_PATTERN_EN to add pattern_sel, which substitutes {y,x} pixels for memory reads.
module camera_stream_tx #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int ADDR_W    = 17,
  parameter int VSYNC_CYC = 4,
  parameter int VBP_CYC   = 10,
  parameter int HBLK_CYC  = 8,
  parameter int VFP_CYC   = 10
) (
  input  logic              CAMERA_CLK,
  input  logic              rst,
  input  logic              start,
`ifdef TEST_PATTERN_EN
  input  logic              pattern_sel,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [15:0]       rd_data,
  output logic              vsync,
  output logic              href,
  output logic [7:0]        cam_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_VSYNC = 3'd1;
  localparam logic [2:0] S_VBP   = 3'd2;
  localparam logic [2:0] S_LINE  = 3'd3;
  localparam logic [2:0] S_HBLK  = 3'd4;
  localparam logic [2:0] S_VFP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW = 16;

  logic [2:0]        r_state;
  logic [CW-1:0]     r_cnt;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic              r_phase;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_last;
  logic              r_rdv;
  logic [7:0]        r_lo;
  logic [7:0]        r_cam;
  logic              w_rd_req;
  logic [15:0]       w_src;

  // A read is due two cycles before the pixel's high byte is shown.
  always_comb begin
    w_rd_req = 1'b0;
    case (r_state)
      S_VBP:  w_rd_req = (r_cnt == CW'(VBP_CYC - 2));
      S_HBLK: w_rd_req = (r_cnt == CW'(HBLK_CYC - 2));
      S_LINE: w_rd_req = !r_phase && (r_x != XW'(IMG_W - 1));
      default: w_rd_req = 1'b0;
    endcase
  end

`ifdef TEST_PATTERN_EN
  logic          r_pat_mode;
  logic [XW-1:0] r_rx;
  logic [YW-1:0] r_ry;
  logic [15:0]   r_pat;

  always_comb begin
    rd_en = w_rd_req & ~r_pat_mode;
    w_src = r_pat_mode ? r_pat : rd_data;
  end

  // Pattern pixels follow the same one-cycle latency as the RAM path.
  always_ff @(posedge CAMERA_CLK or negedge rst) begin
    if (!rst) begin
      r_pat_mode <= 1'b0;
      r_rx       <= '0;
      r_ry       <= '0;
      r_pat      <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_pat_mode <= pattern_sel;
        r_rx       <= '0;
        r_ry       <= '0;
      end else if (w_rd_req) begin
        r_pat <= {8'(r_ry), 8'(r_rx)};
        if (r_rx == XW'(IMG_W - 1)) begin
          r_rx <= '0;
          r_ry <= r_ry + 1'b1;
        end else begin
          r_rx <= r_rx + 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    rd_en = w_rd_req;
    w_src = rd_data;
  end
`endif

  always_ff @(posedge CAMERA_CLK or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_phase <= 1'b0;
      r_addr  <= '0;
      r_last  <= '0;
      r_rdv   <= 1'b0;
      r_lo    <= '0;
      r_cam   <= '0;
    end else begin
      r_rdv <= w_rd_req;
      if (w_rd_req) r_addr <= r_addr + 1'b1;
      if (rd_en)    r_last <= r_addr;

      if (r_rdv) begin
        r_lo  <= w_src[7:0];
        r_cam <= w_src[15:8];
      end else if (r_state == S_LINE && !r_phase) begin
        r_cam <= r_lo;
      end else begin
        r_cam <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_VSYNC;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_phase <= 1'b0;
          end
        end
        S_VSYNC: begin
          if (r_cnt == CW'(VSYNC_CYC - 1)) begin
            r_state <= S_VBP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_VBP, S_HBLK: begin
          if ((r_state == S_VBP  && r_cnt == CW'(VBP_CYC - 1)) ||
              (r_state == S_HBLK && r_cnt == CW'(HBLK_CYC - 1))) begin
            r_state <= S_LINE;
            r_x     <= '0;
            r_phase <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_LINE: begin
          r_phase <= ~r_phase;
          if (r_phase) begin
            if (r_x == XW'(IMG_W - 1)) begin
              r_x   <= '0;
              r_cnt <= '0;
              if (r_y == YW'(IMG_H - 1)) begin
                r_y     <= '0;
                r_state <= S_VFP;
              end else begin
                r_y     <= r_y + 1'b1;
                r_state <= S_HBLK;
              end
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        S_VFP: begin
          if (r_cnt == CW'(VFP_CYC - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_addr  <= '0;
          r_last  <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    vsync      = (r_state == S_VSYNC);
    href       = (r_state == S_LINE);
    frame_done = (r_state == S_DONE);
    cam_data   = r_cam;
    rd_addr    = rd_en ? r_addr : r_last;
  end

endmodule

// File: tb/tb_camera_stream_tx.sv
// Scoreboard bench for camera_stream_tx on a 4x2 frame with short porches.
module tb_camera_stream_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, frame_done, rd_en, vsync, href;
  logic [2:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic [7:0]  cam_data;
`ifdef TEST_PATTERN_EN
  logic        pattern_sel;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [7:0]  byte_q[$];
  logic [2:0]  addr_q[$];

  camera_stream_tx #(
    .IMG_W(4), .IMG_H(2), .ADDR_W(3),
    .VSYNC_CYC(3), .VBP_CYC(2), .HBLK_CYC(2), .VFP_CYC(2)
  ) dut (
    .CAMERA_CLK(clk),
    .rst(rst),
    .start(start),
`ifdef TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .busy(busy),
    .frame_done(frame_done),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .vsync(vsync),
    .href(href),
    .cam_data(cam_data)
  );

  always #5 clk = ~clk;

  // Frame memory model: mem[a] = A000 + a, one-cycle read latency.
  always @(posedge clk) begin
    if (rd_en) rd_data <= 16'hA000 + 16'(rd_addr);
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input bit pat);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        int a;
        a = y * 4 + x;
        if (pat) begin
          byte_q.push_back(8'(y));
          byte_q.push_back(8'(x));
        end else begin
          byte_q.push_back(8'hA0);
          byte_q.push_back(8'(a));
          addr_q.push_back(3'(a));
        end
      end
    end
  endtask

  // {busy, vsync, href, frame_done, rd_en} expected at cycle k of a frame.
  function automatic logic [4:0] exp_ctl(input int k, input bit pat);
    logic bz, vs, hr, dn, re;
    bz = (k >= 1 && k <= 26);
    vs = (k >= 1 && k <= 3);
    hr = (k >= 6 && k <= 13) || (k >= 16 && k <= 23);
    dn = (k == 26);
    re = !pat && (k == 4 || k == 6 || k == 8 || k == 10 ||
                  k == 14 || k == 16 || k == 18 || k == 20);
    return {bz, vs, hr, dn, re};
  endfunction

  task automatic check_cycle(input int k, input bit pat);
    logic [7:0] eb;
    logic [2:0] ea;
    check_val($sformatf("ctl@%0d", k), {busy, vsync, href, frame_done, rd_en}, exp_ctl(k, pat));
    if (href) begin
      eb = (byte_q.size() > 0) ? byte_q.pop_front() : 8'hxx;
      check_val($sformatf("byte@%0d", k), cam_data, eb);
    end else begin
      check_val($sformatf("blank@%0d", k), cam_data, 8'h00);
    end
    if (rd_en) begin
      ea = (addr_q.size() > 0) ? addr_q.pop_front() : 3'bxxx;
      check_val($sformatf("addr@%0d", k), rd_addr, ea);
    end
    if (k == 27) check_val("idle_addr", rd_addr, 3'd0);
  endtask

  task automatic run_frame(input bit pat, input bit extra, input bit chain, input int rst_at);
    for (int k = 1; k <= 27; k++) begin
      check_cycle(k, pat);
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check_val("rst_async", {busy, frame_done, vsync, href, rd_en, cam_data, rd_addr}, '0);
        for (int i = 0; i < 4; i++) begin
          tick;
          check_val("rst_hold", {busy, frame_done, vsync, href, rd_en, cam_data, rd_addr}, '0);
        end
        #2 rst = 1'b1;
        byte_q.delete();
        addr_q.delete();
        return;
      end
      if (k == 27) begin
        check_val("bytes_left", byte_q.size(), 0);
        check_val("reads_left", addr_q.size(), 0);
        if (chain) push_frame(pat);
      end
      start = (extra && (k == 10 || k == 26)) || (chain && k == 27);
      tick;
      start = 1'b0;
    end
  endtask

  task automatic launch(input bit pat);
    push_frame(pat);
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
`ifdef TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif
    #3;
    check_val("reset", {busy, frame_done, vsync, href, rd_en, cam_data, rd_addr}, '0);
    tick;
    tick;
    rst = 1'b1;
    tick;

    launch(1'b0);
    run_frame(1'b0, 1'b1, 1'b1, 0);
    run_frame(1'b0, 1'b0, 1'b0, 0);
    tick;

    launch(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 12);
    tick;
    launch(1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 0);

`ifdef TEST_PATTERN_EN
    tick;
    pattern_sel = 1'b1;
    launch(1'b1);
    pattern_sel = 1'b0;
    run_frame(1'b1, 1'b0, 1'b0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
